// File: rtl/image_window_ctrl_if.sv
// image_window_ctrl_if: pixel stream in, 3x3 window stream out, plus status flags
interface image_window_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        i_out_ready;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
    logic        o_overflow;
    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_out_ready,
        output o_pixel_data, o_pixel_data_valid, o_intr, o_overflow
    );
    modport master (
        output i_pixel_data, i_pixel_data_valid, i_out_ready,
        input  o_pixel_data, o_pixel_data_valid, o_intr, o_overflow
    );
endinterface

// File: rtl/image_window_ctrl.sv
// image_window_ctrl: four-line ring buffer emitting 3x3 windows once three lines are held
module image_window_ctrl #(
    parameter int LINE_WIDTH = 512,
    parameter int PTR_W      = 9,
    parameter int CNT_W      = 12
) (
    input logic             i_clk,
    input logic             i_rst,
    image_window_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RD} state_t;
    localparam logic [PTR_W-1:0] COL_LAST = PTR_W'(LINE_WIDTH - 1);
    localparam logic [PTR_W-1:0] RD_LAST  = PTR_W'(LINE_WIDTH - 3);
    localparam logic [CNT_W-1:0] LW       = CNT_W'(LINE_WIDTH);
    localparam logic [CNT_W-1:0] THREE    = CNT_W'(3 * LINE_WIDTH);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(4 * LINE_WIDTH);
    state_t           state, state_nx;
    logic [7:0]       mem [4][LINE_WIDTH];
    logic [PTR_W-1:0] wr_col, rd_col, c1, c2;
    logic [1:0]       wr_line, rd_line, m_line, b_line;
    logic [CNT_W-1:0] total;
    logic             rd_en, rel, wr_en, drop;
    logic [71:0]      win;
    // Read/release strobes, write acceptance and next state
    always_comb begin
        rd_en    = state == RD && bus.i_out_ready;
        rel      = rd_en && rd_col == RD_LAST;
        wr_en    = bus.i_pixel_data_valid && !(total == FULL && !rel);
        drop     = bus.i_pixel_data_valid && !wr_en;
        state_nx = state == IDLE ? (total >= THREE ? RD : IDLE) : (rel ? IDLE : RD);
    end
    // Window gather: top/middle/bottom lines, leftmost pixel in the high byte
    always_comb begin
        c1     = rd_col + PTR_W'(1);
        c2     = rd_col + PTR_W'(2);
        m_line = rd_line + 2'd1;
        b_line = rd_line + 2'd2;
        win    = {mem[rd_line][rd_col], mem[rd_line][c1], mem[rd_line][c2],
                  mem[m_line][rd_col],  mem[m_line][c1],  mem[m_line][c2],
                  mem[b_line][rd_col],  mem[b_line][c1],  mem[b_line][c2]};
    end
    // Line store write port; contents deliberately survive reset
    always_ff @(posedge i_clk)
        if (wr_en) mem[wr_line][wr_col] <= bus.i_pixel_data;
    // State register
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    // Pointers, occupancy count and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_col                 <= '0;
            wr_line                <= '0;
            rd_col                 <= '0;
            rd_line                <= '0;
            total                  <= '0;
            bus.o_pixel_data       <= '0;
            bus.o_pixel_data_valid <= 1'b0;
            bus.o_intr             <= 1'b0;
            bus.o_overflow         <= 1'b0;
        end else begin
            if (wr_en) wr_col <= wr_col == COL_LAST ? '0 : wr_col + PTR_W'(1);
            if (wr_en && wr_col == COL_LAST) wr_line <= wr_line + 2'd1;
            total <= total + CNT_W'(wr_en) - (rel ? LW : '0);
            rd_col <= rel ? '0 : (rd_en ? rd_col + PTR_W'(1) : rd_col);
            if (rel) rd_line <= rd_line + 2'd1;
            if (rd_en) bus.o_pixel_data <= win;
            bus.o_pixel_data_valid <= rd_en;
            bus.o_intr             <= rel;
            if (drop) bus.o_overflow <= 1'b1;
        end
    end
endmodule
